// File: rtl/evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : evt_pkg
// Brief    : Shared constants for the event FIFO write-side arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package evt_pkg;

    localparam int         EVT_W       = 33;
    localparam int         EOE_BIT     = 32;
    localparam logic [7:0] TRAILER_TAG = 8'hEE;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

endpackage : evt_pkg
`default_nettype wire

// File: rtl/evt_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : evt_rr_pick
// Brief    : Combinational round-robin selector: first requester after last.
// Revision : 1.0 - initial release
// ============================================================================
module evt_rr_pick
    import evt_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);

    localparam int               c_SW = IDX_W + 1;
    localparam logic [c_SW-1:0]  c_N  = c_SW'(N_SRC);

    logic [c_SW-1:0] w_cand;

    // Scan from the farthest offset back to the nearest, so the nearest hit wins.
    always_comb begin
        hit    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = N_SRC; i >= 1; i--) begin
            w_cand = {1'b0, last} + c_SW'(i);
            if (w_cand >= c_N) begin
                w_cand = w_cand - c_N;
            end
            if (req[w_cand[IDX_W-1:0]]) begin
                hit = 1'b1;
                idx = w_cand[IDX_W-1:0];
            end
        end
    end

endmodule : evt_rr_pick
`default_nettype wire

// File: rtl/evt_fifo_arb.sv
`default_nettype none
// ============================================================================
// Module   : evt_fifo_arb
// Brief    : Event-granular round-robin arbiter sharing one 33-bit data FIFO
//            write port. Define EVT_ARB_TIMEOUT_EN to abort stalled events.
// Revision : 1.0 - initial release
// ============================================================================
module evt_fifo_arb
    import evt_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_SRC*EVT_W-1:0]   src_data_i,
    input  logic [N_SRC-1:0]         src_valid_i,
    output logic [N_SRC-1:0]         src_ready_o,
    output logic [EVT_W-1:0]         fifo_data_o,
    output logic                     fifo_we_o,
    input  logic                     fifo_full_i,
    output logic                     busy_o,
    output logic [$clog2(N_SRC)-1:0] grant_o,
    output logic [CNT_W-1:0]         evt_cnt_o,
    output logic                     to_err_o
);

    localparam int c_GW = $clog2(N_SRC);

    logic [0:0]       r_state;
    logic [c_GW-1:0]  r_grant;
    logic [c_GW-1:0]  r_last;
    logic [CNT_W-1:0] r_evt_cnt;

    logic [EVT_W-1:0] w_words [N_SRC];
    logic [EVT_W-1:0] w_src_word;
    logic             w_hit;
    logic [c_GW-1:0]  w_pick;
    logic             w_busy;
    logic             w_gvalid;
    logic             w_accept;
    logic             w_to_hit;
    logic             w_eoe_wr;

    if (N_SRC < 2 || TIMEOUT < 1) begin : g_param_guard
    end

    for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
        assign w_words[k] = src_data_i[k*EVT_W +: EVT_W];
    end

    evt_rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (c_GW)
    ) u_pick (
        .req  (src_valid_i),
        .last (r_last),
        .hit  (w_hit),
        .idx  (w_pick)
    );

    assign w_busy     = (r_state == ST_BUSY);
    assign w_src_word = w_words[r_grant];
    assign w_gvalid   = src_valid_i[r_grant];
    assign w_accept   = w_busy && !w_to_hit && w_gvalid && !fifo_full_i;

`ifdef EVT_ARB_TIMEOUT_EN
    localparam int              c_TW      = $clog2(TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_TIMEOUT = c_TW'(TIMEOUT);

    logic [c_TW-1:0] r_idle_cnt;
    logic            r_to_err;

    assign w_to_hit = w_busy && (r_idle_cnt == c_TIMEOUT);

    // Only source-starved cycles count; full-FIFO backpressure never aborts an event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idle_cnt <= '0;
            r_to_err   <= 1'b0;
        end else if (!w_busy || w_accept) begin
            r_idle_cnt <= '0;
        end else if (w_to_hit) begin
            if (!fifo_full_i) begin
                r_idle_cnt <= '0;
                r_to_err   <= 1'b1;
            end
        end else if (!w_gvalid && !fifo_full_i) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    assign to_err_o    = r_to_err;
    assign fifo_data_o = w_to_hit ? {1'b1, TRAILER_TAG, 8'(r_grant), 16'h0000} : w_src_word;
`else
    assign w_to_hit    = 1'b0;
    assign to_err_o    = 1'b0;
    assign fifo_data_o = w_src_word;
`endif

    always_comb begin
        src_ready_o = '0;
        if (w_busy && !w_to_hit) begin
            src_ready_o[r_grant] = !fifo_full_i;
        end
    end

    // The trailer also carries EOE, so both event endings share one path.
    assign fifo_we_o = w_accept || (w_to_hit && !fifo_full_i);
    assign w_eoe_wr  = fifo_we_o && fifo_data_o[EOE_BIT];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_last    <= c_GW'(N_SRC - 1);
            r_evt_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        r_grant <= w_pick;
                        r_last  <= w_pick;
                        r_state <= ST_BUSY;
                    end
                end
                default: begin
                    if (w_eoe_wr) begin
                        r_evt_cnt <= r_evt_cnt + 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy_o    = w_busy;
    assign grant_o   = r_grant;
    assign evt_cnt_o = r_evt_cnt;

endmodule : evt_fifo_arb
`default_nettype wire
